// File: rtl/logic_seq.sv
// logic_seq: four-register sequencer that issues operands to an external 8-bit
// logic unit, captures its result one cycle later and writes it back.
// Each instruction takes IDLE -> EXEC -> WB; register preloads are only taken in IDLE.
module logic_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_valid,
  output logic       inst_ready,
  input  logic [1:0] inst_op,
  input  logic [1:0] inst_rd,
  input  logic [1:0] inst_ra,
  input  logic [1:0] inst_rb,
  input  logic       ld_we,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] op_A,
  output logic [7:0] op_B,
  output logic [1:0] op_mux,
  input  logic [7:0] Func,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [1:0] res_rd,
  output logic       res_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] regs [4];
  logic [1:0] pend_rd;
  logic       accept;

  assign rd_data = regs[rd_addr];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake, writeback strobe and next-state selection.
  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    accept     = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        // A preload in the same cycle blocks acceptance, so operands never need a bypass.
        inst_ready = ~ld_we & ~rst;
        accept     = inst_ready & inst_valid;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register file: preload in IDLE, result writeback in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (state == IDLE && ld_we) begin
      regs[ld_addr] <= ld_data;
    end else if (state == WB) begin
      regs[res_rd] <= res_data;
    end
  end

  // Operand capture at acceptance, result capture in EXEC, operand clear after WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_A     <= '0;
      op_B     <= '0;
      op_mux   <= '0;
      pend_rd  <= '0;
      res_data <= '0;
      res_rd   <= '0;
      res_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_A    <= regs[inst_ra];
            op_B    <= regs[inst_rb];
            op_mux  <= inst_op;
            pend_rd <= inst_rd;
          end
        end
        EXEC: begin
          res_data <= Func;
          res_zero <= (Func == 8'h00);
          res_rd   <= pend_rd;
        end
        WB: begin
          op_A   <= '0;
          op_B   <= '0;
          op_mux <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_seq.sv
// Self-checking bench for logic_seq: models the external logic unit, keeps a
// register model, and scoreboards every writeback against the expected result.
module tb_logic_seq;

  logic       clk;
  logic       rst;
  logic       inst_valid;
  logic       inst_ready;
  logic [1:0] inst_op;
  logic [1:0] inst_rd;
  logic [1:0] inst_ra;
  logic [1:0] inst_rb;
  logic       ld_we;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] op_A;
  logic [7:0] op_B;
  logic [1:0] op_mux;
  logic [7:0] Func;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_rd;
  logic       res_zero;

  logic_seq dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_op    (inst_op),
    .inst_rd    (inst_rd),
    .inst_ra    (inst_ra),
    .inst_rb    (inst_rb),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .op_A       (op_A),
    .op_B       (op_B),
    .op_mux     (op_mux),
    .Func       (Func),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .res_zero   (res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // External logic unit.
  always_comb Func = lu(op_mux, op_A, op_B);

  typedef struct {
    logic [1:0] rd;
    logic [7:0] data;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [3:0]  ld_mask;
    logic [31:0] ld_vals;   // {R3, R2, R1, R0}
    logic [1:0]  op;
    logic [1:0]  rd;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [7:0]  exp_data;
    logic        exp_zero;
    bit          disturb;
  } vec_t;

  exp_t       sbq [$];
  int         pulses [$];
  logic [7:0] model [4];
  vec_t       vecs [8];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample 1ns after the edge and retire any writeback.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (res_valid && !rst) begin
      pulses.push_back(cyc);
      chk("sb_pending", 32'(sbq.size()), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_res_data", 32'(res_data), 32'(e.data));
        chk("sb_res_rd",   32'(res_rd),   32'(e.rd));
        chk("sb_res_zero", 32'(res_zero), 32'(e.zero));
        model[e.rd] = e.data;
      end
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk($sformatf("reg_R%0d", i), 32'(rd_data), 32'(model[i]));
    end
  endtask

  task automatic load(input logic [1:0] addr, input logic [7:0] data);
    ld_we   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_we = 1'b0;
    model[addr] = data;
    rd_addr = addr;
    #1;
    chk("load_readback", 32'(rd_data), 32'(data));
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
    exp_t e;
    e.rd   = rd;
    e.data = lu(op, model[ra], model[rb]);
    e.zero = (e.data == 8'h00);
    sbq.push_back(e);
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb, input logic [7:0] exp_d, input logic exp_z,
                           input bit disturb);
    logic       acc;
    logic [7:0] ea;
    logic [7:0] eb;
    acc = 1'b0;
    ea  = '0;
    eb  = '0;
    inst_op = op; inst_rd = rd; inst_ra = ra; inst_rb = rb;
    inst_valid = 1'b1;
    for (int c = 0; c < 8 && !acc; c++) begin
      #1;
      acc = inst_ready;
      if (acc) begin
        ea = model[ra];
        eb = model[rb];
        push_exp(op, rd, ra, rb);
      end
      tick();
    end
    inst_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    if (!acc) return;
    // EXEC
    if (disturb) begin
      ld_we = 1'b1; ld_addr = ra; ld_data = 8'h5A;
      inst_valid = 1'b1; inst_op = ~op; inst_rd = ~rd; inst_ra = ~ra; inst_rb = ~rb;
    end
    #1;
    chk("exec_ready", 32'(inst_ready), 32'd0);
    chk("exec_opA",   32'(op_A),       32'(ea));
    chk("exec_opB",   32'(op_B),       32'(eb));
    chk("exec_opmux", 32'(op_mux),     32'(op));
    chk("exec_valid", 32'(res_valid),  32'd0);
    tick();
    // WB
    chk("wb_valid",  32'(res_valid),  32'd1);
    chk("wb_data",   32'(res_data),   32'(exp_d));
    chk("wb_zero",   32'(res_zero),   32'(exp_z));
    chk("wb_rd",     32'(res_rd),     32'(rd));
    chk("wb_ready",  32'(inst_ready), 32'd0);
    chk("wb_opmux",  32'(op_mux),     32'(op));
    tick();
    // back in IDLE
    ld_we = 1'b0;
    inst_valid = 1'b0;
    chk("idle_valid",   32'(res_valid), 32'd0);
    chk("idle_opA",     32'(op_A),      32'd0);
    chk("idle_opB",     32'(op_B),      32'd0);
    chk("idle_opmux",   32'(op_mux),    32'd0);
    chk("idle_resdata", 32'(res_data),  32'(exp_d));
    chk("idle_reszero", 32'(res_zero),  32'(exp_z));
    rd_addr = rd;
    #1;
    chk("dest_readback", 32'(rd_data), 32'(exp_d));
    check_regs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},   32'(inst_ready), 32'd0);
    chk({tag, "_opA"},     32'(op_A),       32'd0);
    chk({tag, "_opB"},     32'(op_B),       32'd0);
    chk({tag, "_opmux"},   32'(op_mux),     32'd0);
    chk({tag, "_valid"},   32'(res_valid),  32'd0);
    chk({tag, "_resdata"}, 32'(res_data),   32'd0);
    chk({tag, "_resrd"},   32'(res_rd),     32'd0);
    chk({tag, "_reszero"}, 32'(res_zero),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0011, 32'h0000_3CF0, 2'd2, 2'd2, 2'd0, 2'd1, 8'hCC, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 32'h0000_F00F, 2'd1, 2'd3, 2'd0, 2'd1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{4'b0100, 32'h0055_0000, 2'd3, 2'd2, 2'd2, 2'd0, 8'hAA, 1'b0, 1'b0};
    vecs[3] = '{4'b0000, 32'h0000_0000, 2'd0, 2'd0, 2'd2, 2'd2, 8'hAA, 1'b0, 1'b0};
    vecs[4] = '{4'b0000, 32'h0000_0000, 2'd2, 2'd1, 2'd1, 2'd1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{4'b0000, 32'h0000_0000, 2'd0, 2'd3, 2'd0, 2'd2, 8'hAA, 1'b0, 1'b1};
    vecs[6] = '{4'b0000, 32'h0000_0000, 2'd3, 2'd1, 2'd1, 2'd3, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{4'b0000, 32'h0000_0000, 2'd1, 2'd0, 2'd1, 2'd0, 8'hAA, 1'b0, 1'b0};

    rst = 1'b0; inst_valid = 1'b0; inst_op = '0; inst_rd = '0; inst_ra = '0; inst_rb = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;

    // Reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst");
    tick();
    chk("rst_ready_held", 32'(inst_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(inst_ready), 32'd1);
    check_regs();

    // Table-driven instructions with optional preloads.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++)
        if (vecs[i].ld_mask[j]) load(2'(j), vecs[i].ld_vals[j*8 +: 8]);
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb,
                vecs[i].exp_data, vecs[i].exp_zero, vecs[i].disturb);
    end

    // Preload and instruction offered together: load wins, no acceptance.
    ld_we = 1'b1; ld_addr = 2'd3; ld_data = 8'h81;
    inst_valid = 1'b1; inst_op = 2'd0; inst_rd = 2'd0; inst_ra = 2'd3; inst_rb = 2'd3;
    #1;
    chk("ld_blocks_ready", 32'(inst_ready), 32'd0);
    tick();
    ld_we = 1'b0;
    inst_valid = 1'b0;
    model[3] = 8'h81;
    chk("ld_no_accept_opA",   32'(op_A),   32'd0);
    chk("ld_no_accept_opmux", 32'(op_mux), 32'd0);
    rd_addr = 2'd3;
    #1;
    chk("ld_with_valid_R3", 32'(rd_data), 32'h81);
    run_instr(2'd0, 2'd0, 2'd3, 2'd3, 8'h81, 1'b0, 1'b0);

    // Back-to-back instructions with inst_valid held high.
    begin
      logic [1:0] q_op [3];
      logic [1:0] q_rd [3];
      logic [1:0] q_ra [3];
      logic [1:0] q_rb [3];
      int idx;
      q_op = '{2'd2, 2'd0, 2'd1};
      q_rd = '{2'd0, 2'd1, 2'd2};
      q_ra = '{2'd1, 2'd0, 2'd0};
      q_rb = '{2'd2, 2'd3, 2'd1};
      idx = 0;
      pulses.delete();
      inst_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
        if (idx < 3) begin
          inst_op = q_op[idx]; inst_rd = q_rd[idx]; inst_ra = q_ra[idx]; inst_rb = q_rb[idx];
        end
        #1;
        chk($sformatf("stream_ready_c%0d", c), 32'(inst_ready), 32'((c % 3) == 0));
        if (inst_ready && idx < 3) begin
          push_exp(q_op[idx], q_rd[idx], q_ra[idx], q_rb[idx]);
          idx++;
        end
        tick();
      end
      inst_valid = 1'b0;
      chk("stream_accepted", 32'(idx), 32'd3);
      chk("stream_pulses", 32'(pulses.size()), 32'd3);
      if (pulses.size() == 3) begin
        chk("stream_gap1", 32'(pulses[1] - pulses[0]), 32'd3);
        chk("stream_gap2", 32'(pulses[2] - pulses[1]), 32'd3);
      end
      check_regs();
    end

    // Reset during EXEC aborts the instruction.
    load(2'd0, 8'h12);
    load(2'd2, 8'h40);
    inst_op = 2'd0; inst_rd = 2'd1; inst_ra = 2'd0; inst_rb = 2'd2;
    inst_valid = 1'b1;
    #1;
    chk("abort_ready", 32'(inst_ready), 32'd1);
    tick();
    inst_valid = 1'b0;
    chk("abort_exec_opA", 32'(op_A), 32'h12);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    check_regs_zero: for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk($sformatf("abort_R%0d", i), 32'(rd_data), 32'd0);
    end
    sbq.delete();
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("abort_no_valid_c%0d", c), 32'(res_valid), 32'd0);
    end
    rd_addr = 2'd1;
    #1;
    chk("abort_R1_clear", 32'(rd_data), 32'd0);
    chk("abort_ready_after", 32'(inst_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
